// File: rtl/result_tx_arbiter_if.sv
// Handshake bundle between the result TX arbiter, the two matrix memories
// and the UART transmitter.
interface result_tx_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic [1:0]        start_req;
    logic [1:0]        mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_data0;
    logic [15:0]       mem_data1;
    logic              tx_start;
    logic [7:0]        tx_byte;
    logic              tx_busy;
    logic [1:0]        grant;
    logic [1:0]        done;
    logic              busy;

    modport master (
        input  start_req, mem_data0, mem_data1, tx_busy,
        output mem_rd, mem_addr, tx_start, tx_byte, grant, done, busy
    );

    modport slave (
        output start_req, mem_data0, mem_data1, tx_busy,
        input  mem_rd, mem_addr, tx_start, tx_byte, grant, done, busy
    );
endinterface

// File: rtl/result_tx_arbiter.sv
// Round-robin sequencer streaming one of two result-matrix memories
// through a shared UART transmitter, low byte first.
module result_tx_arbiter #(
    parameter int ROWS   = 2,
    parameter int COLS   = 2,
    parameter int ADDR_W = 32
) (
    input logic                 slow_clk,
    input logic                 rst,
    result_tx_arbiter_if.master bus
);
    localparam int N     = ROWS * COLS;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [3:0] {
        IDLE,
        ARB,
        READ,
        LATCH,
        SEND_LO,
        WAIT_LO,
        SEND_HI,
        WAIT_HI,
        NEXT
    } state_t;

    state_t           state, state_n;
    logic [1:0]       pending, pending_n;
    logic             last, last_n;
    logic [1:0]       gnt, gnt_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [15:0]      word, word_n;
    logic [7:0]       held, held_n;
    logic [1:0]       pick;
    logic [15:0]      rd_data;

    // On a tie the requester not served last time wins.
    always_comb begin
        pick = pending;
        if (pending == 2'b11) begin
            pick = last ? 2'b01 : 2'b10;
        end
    end

    assign rd_data      = gnt[1] ? bus.mem_data1 : bus.mem_data0;
    assign bus.mem_addr = ADDR_W'(idx);

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pending <= 2'b00;
            last    <= 1'b1;
            gnt     <= 2'b00;
            idx     <= '0;
            word    <= 16'h0000;
            held    <= 8'h00;
        end else begin
            state   <= state_n;
            pending <= pending_n;
            last    <= last_n;
            gnt     <= gnt_n;
            idx     <= idx_n;
            word    <= word_n;
            held    <= held_n;
        end
    end

    always_comb begin
        state_n      = state;
        pending_n    = pending | bus.start_req;
        last_n       = last;
        gnt_n        = gnt;
        idx_n        = idx;
        word_n       = word;
        held_n       = held;
        bus.mem_rd   = 2'b00;
        bus.tx_start = 1'b0;
        bus.tx_byte  = held;
        bus.grant    = gnt;
        bus.done     = 2'b00;
        bus.busy     = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (pending != 2'b00) state_n = ARB;
            end
            ARB: begin
                bus.grant = pick;
                gnt_n     = pick;
                last_n    = pick[1];
                // A fresh request on this edge survives the clear.
                pending_n = (pending & ~pick) | bus.start_req;
                idx_n     = '0;
                state_n   = READ;
            end
            READ: begin
                bus.mem_rd = gnt;
                state_n    = LATCH;
            end
            LATCH: begin
                word_n  = rd_data;
                state_n = SEND_LO;
            end
            SEND_LO: begin
                bus.tx_start = 1'b1;
                bus.tx_byte  = word[7:0];
                held_n       = word[7:0];
                state_n      = WAIT_LO;
            end
            WAIT_LO: begin
                if (!bus.tx_busy) state_n = SEND_HI;
            end
            SEND_HI: begin
                bus.tx_start = 1'b1;
                bus.tx_byte  = word[15:8];
                held_n       = word[15:8];
                state_n      = WAIT_HI;
            end
            WAIT_HI: begin
                if (!bus.tx_busy) state_n = NEXT;
            end
            NEXT: begin
                if (idx == LAST_IDX) begin
                    bus.done = gnt;
                    gnt_n    = 2'b00;
                    state_n  = IDLE;
                end else begin
                    idx_n   = idx + 1'b1;
                    state_n = READ;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
